// File: rtl/bcd_down_timer_if.sv
// ---------------------------------------------------------------------------
// bcd_down_timer_if
//   Bundles the control, preset and status signals of bcd_down_timer.
//   master : the controlling side (drives tick/load/start/stop/preset,
//            observes count/running/zero/done)
//   slave  : the timer itself
//   Parameter DIGITS sets the number of BCD decades (count width 4*DIGITS).
// ---------------------------------------------------------------------------
interface bcd_down_timer_if #(
  parameter int DIGITS = 3
);
  logic                  tick;
  logic                  load;
  logic                  start;
  logic                  stop;
  logic [4*DIGITS-1:0]   preset;
  logic [4*DIGITS-1:0]   count;
  logic                  running;
  logic                  zero;
  logic                  done;

  modport master (
    output tick, load, start, stop, preset,
    input  count, running, zero, done
  );

  modport slave (
    input  tick, load, start, stop, preset,
    output count, running, zero, done
  );
endinterface

// File: rtl/bcd_down_timer.sv
// ---------------------------------------------------------------------------
// bcd_down_timer
//   Loadable multi-decade BCD countdown timer. Counts a preset down to zero
//   on prescaler ticks, pulses done for one cycle on reaching zero from RUN,
//   then stops in IDLE.
// Ports
//   clk      : system clock, all state on rising edge
//   reset_n  : asynchronous active-low reset
//   bus      : bcd_down_timer_if.slave
//              in : tick, load, start, stop, preset[4*DIGITS-1:0]
//              out: count[4*DIGITS-1:0], running, zero, done
//   Digit 0 (ones) lives in bits [3:0] of preset and count.
// ---------------------------------------------------------------------------
module bcd_down_timer #(
  parameter int DIGITS = 3
) (
  input  logic             clk,
  input  logic             reset_n,
  bcd_down_timer_if.slave  bus
);
  localparam int W = 4 * DIGITS;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_e;

  state_e         state_q, state_d;
  logic [W-1:0]   count_q, count_d;
  logic           done_q, done_d;

  logic [W-1:0]   preset_clamped;
  logic [W-1:0]   count_dec;
  logic [DIGITS-1:0] borrow;   // borrow[gi] = digit gi must be decremented

  // Per-digit clamp of the preset (A..F become 9) and a rippling BCD
  // decrement. The borrow ripples through all decades within one cycle.
  assign borrow[0] = 1'b1;

  generate
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
      logic [3:0] pre_digit;
      logic [3:0] cur_digit;

      assign pre_digit = bus.preset[4*gi +: 4];
      assign cur_digit = count_q[4*gi +: 4];

      assign preset_clamped[4*gi +: 4] = (pre_digit > 4'd9) ? 4'd9 : pre_digit;

      assign count_dec[4*gi +: 4] = !borrow[gi]          ? cur_digit :
                                    (cur_digit == 4'd0)  ? 4'd9      :
                                                           cur_digit - 4'd1;
      if (gi < DIGITS - 1) begin : g_borrow
        assign borrow[gi+1] = borrow[gi] & (cur_digit == 4'd0);
      end
    end
  endgenerate

  // Next-state logic. Priority: load > stop > start > tick.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    done_d  = 1'b0;

    if (bus.load) begin
      count_d = preset_clamped;
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          // Never enter RUN with a zero count, so no underflow is possible.
          if (!bus.stop && bus.start && (count_q != '0)) begin
            state_d = RUN;
          end
        end
        RUN: begin
          if (bus.stop) begin
            state_d = PAUSE;
          end else if (bus.tick) begin
            count_d = count_dec;
            if (count_dec == '0) begin
              state_d = IDLE;
              done_d  = 1'b1;
            end
          end
        end
        PAUSE: begin
          if (!bus.stop && bus.start) begin
            state_d = RUN;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      count_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      done_q  <= done_d;
    end
  end

  assign bus.count   = count_q;
  assign bus.running = (state_q == RUN);
  assign bus.zero    = (count_q == '0);
  assign bus.done    = done_q;

endmodule

// File: tb/tb_bcd_down_timer.sv
module tb_bcd_down_timer;
  localparam int DIGITS = 3;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   total = 0;
  int   bad   = 0;

  // Reference model: count kept as a plain decimal integer.
  int   m_val   = 0;
  int   m_state = 0;   // 0 idle, 1 counting, 2 paused
  bit   m_done  = 1'b0;

  bcd_down_timer_if #(.DIGITS(DIGITS)) bus ();

  bcd_down_timer #(.DIGITS(DIGITS)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [11:0] to_bcd(input int v);
    logic [11:0] r;
    r[3:0]  = 4'(v % 10);
    r[7:4]  = 4'((v / 10) % 10);
    r[11:8] = 4'((v / 100) % 10);
    return r;
  endfunction

  function automatic int preset_value(input logic [11:0] p);
    int v = 0;
    int w = 1;
    for (int i = 0; i < 3; i++) begin
      int d = int'(p[4*i +: 4]);
      if (d > 9) d = 9;
      v = v + d * w;
      w = w * 10;
    end
    return v;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".count"},   32'(bus.count),   32'(to_bcd(m_val)));
    check({tag, ".running"}, 32'(bus.running), 32'(m_state == 1));
    check({tag, ".zero"},    32'(bus.zero),    32'(m_val == 0));
    check({tag, ".done"},    32'(bus.done),    32'(m_done));
  endtask

  function automatic void model_step(input bit tk, input bit ld, input bit st,
                                     input bit sp, input logic [11:0] pre);
    m_done = 1'b0;
    if (ld) begin
      m_val   = preset_value(pre);
      m_state = 0;
    end else if (m_state == 0) begin
      if (!sp && st && m_val != 0) m_state = 1;
    end else if (m_state == 1) begin
      if (sp) m_state = 2;
      else if (tk) begin
        m_val = m_val - 1;
        if (m_val == 0) begin
          m_state = 0;
          m_done  = 1'b1;
        end
      end
    end else begin
      if (!sp && st) m_state = 1;
    end
  endfunction

  // Apply inputs for one clock, then check all outputs 1 time unit after the edge.
  task automatic cyc(input string tag, input bit tk, input bit ld, input bit st,
                     input bit sp, input logic [11:0] pre);
    bus.tick   = tk;
    bus.load   = ld;
    bus.start  = st;
    bus.stop   = sp;
    bus.preset = pre;
    @(posedge clk);
    #1;
    model_step(tk, ld, st, sp, pre);
    $display("%-6s tick=%0b load=%0b start=%0b stop=%0b preset=%03h -> count=%03h run=%0b zero=%0b done=%0b",
             tag, tk, ld, st, sp, pre, bus.count, bus.running, bus.zero, bus.done);
    check_all(tag);
  endtask

  initial begin
    bus.tick = 0; bus.load = 0; bus.start = 0; bus.stop = 0; bus.preset = '0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check_all("rst");
    check("rst.zero_const", 32'(bus.zero), 32'd1);
    #5 reset_n = 1'b1;

    // 1: reset while counting at 457
    cyc("t1", 0, 1, 0, 0, 12'h457);
    cyc("t1", 0, 0, 1, 0, 12'h000);
    check("t1.running", 32'(bus.running), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    m_val = 0; m_state = 0; m_done = 0;
    check("t1.async_count", 32'(bus.count), 32'h000);
    check_all("t1r");
    #2 reset_n = 1'b1;

    // 2: double borrow 100 -> 099
    cyc("t2", 0, 1, 0, 0, 12'h100);
    cyc("t2", 0, 0, 1, 0, 12'h000);
    cyc("t2", 1, 0, 0, 0, 12'h000);
    check("t2.count", 32'(bus.count), 32'h099);
    check("t2.running", 32'(bus.running), 32'd1);

    // 3: terminal decrement with done pulse
    cyc("t3", 0, 1, 0, 0, 12'h003);
    cyc("t3", 0, 0, 1, 0, 12'h000);
    cyc("t3", 1, 0, 0, 0, 12'h000);
    cyc("t3", 1, 0, 0, 0, 12'h000);
    cyc("t3", 1, 0, 0, 0, 12'h000);
    check("t3.done", 32'(bus.done), 32'd1);
    check("t3.running", 32'(bus.running), 32'd0);
    cyc("t3", 1, 0, 0, 0, 12'h000);
    check("t3.done_drop", 32'(bus.done), 32'd0);

    // 4: clamp, load beats tick/start
    cyc("t4", 0, 1, 0, 0, 12'h0A5);
    check("t4.clamp", 32'(bus.count), 32'h095);
    cyc("t4", 0, 0, 1, 0, 12'h000);
    cyc("t4", 1, 1, 1, 0, 12'h2F7);
    check("t4.load_prio", 32'(bus.count), 32'h297);
    check("t4.idle", 32'(bus.running), 32'd0);

    // 5: stop beats tick, pause ignores ticks, resume
    cyc("t5", 0, 1, 0, 0, 12'h050);
    cyc("t5", 0, 0, 1, 0, 12'h000);
    cyc("t5", 1, 0, 0, 1, 12'h000);
    check("t5.hold", 32'(bus.count), 32'h050);
    cyc("t5", 1, 0, 0, 0, 12'h000);
    cyc("t5", 1, 0, 0, 0, 12'h000);
    cyc("t5", 0, 0, 1, 0, 12'h000);
    cyc("t5", 1, 0, 0, 0, 12'h000);
    check("t5.resume", 32'(bus.count), 32'h049);

    // 6: start at zero is ignored
    cyc("t6", 0, 1, 0, 0, 12'h000);
    for (int i = 0; i < 3; i++) cyc("t6", 1, 0, 1, 0, 12'h000);
    check("t6.running", 32'(bus.running), 32'd0);

    // 7: all nines and randomized traffic
    cyc("t7", 0, 1, 0, 0, 12'h999);
    cyc("t7", 0, 0, 1, 0, 12'h000);
    cyc("t7", 1, 0, 0, 0, 12'h000);
    check("t7.max_dec", 32'(bus.count), 32'h998);

    for (int n = 0; n < 400; n++) begin
      logic [11:0] pre;
      pre = ($urandom_range(0, 3) == 0) ? 12'($urandom) : to_bcd($urandom_range(0, 12));
      cyc("rnd", $urandom_range(0, 1) == 1, $urandom_range(0, 24) == 0,
          $urandom_range(0, 5) == 0, $urandom_range(0, 11) == 0, pre);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
